router_fsm: RTL and testbench



---
 rtl/router_fsm.sv | 119 +++++++++++
 tb/tb_router_fsm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router: decodes the header address, sequences header,
// payload and parity loads into the selected FIFO, and stalls while it is full.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       lfd_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned PORTS_P2 = 4;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;

  // Padded to a power of two so the invalid address 3 indexes a constant 0.
  logic [PORTS_P2-1:0] empty_vec;
  logic [PORTS_P2-1:0] soft_vec;
  logic                hdr_ok_c;
  logic                empty_hdr_c;
  logic                empty_sel_c;
  logic                soft_sel_c;

  assign empty_vec   = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec    = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign hdr_ok_c    = pkt_valid && (data_in != ADDR_INVALID);
  assign empty_hdr_c = empty_vec[data_in];
  assign empty_sel_c = empty_vec[addr_q];
  assign soft_sel_c  = soft_vec[addr_q];

  // Next-state logic; a soft reset of the selected port abandons the packet.
  always_comb begin
    next_state = DECODE_ADDRESS;
    unique case (state)
      DECODE_ADDRESS: begin
        if (hdr_ok_c) next_state = empty_hdr_c ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        else          next_state = DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY:  next_state = empty_sel_c ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:  next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
        else                 next_state = LOAD_DATA;
      end
      FIFO_FULL_STATE:  next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      end
      LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            next_state = DECODE_ADDRESS;
    endcase
    if (state != DECODE_ADDRESS && soft_sel_c) next_state = DECODE_ADDRESS;
  end

  // State, address and outputs registered together; outputs are decodes of next_state
  // so each output is a flop that always matches the current state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= DECODE_ADDRESS;
      addr_q        <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      full_state    <= 1'b0;
      laf_state     <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && hdr_ok_c) addr_q <= data_in;
      detect_add    <= (next_state == DECODE_ADDRESS);
      lfd_state     <= (next_state == LOAD_FIRST_DATA);
      ld_state      <= (next_state == LOAD_DATA);
      full_state    <= (next_state == FIFO_FULL_STATE);
      laf_state     <= (next_state == LOAD_AFTER_FULL);
      rst_int_reg   <= (next_state == CHECK_PARITY_ERROR);
      write_enb_reg <= (next_state == LOAD_DATA) || (next_state == LOAD_PARITY) ||
                       (next_state == LOAD_AFTER_FULL);
      busy          <= (next_state != DECODE_ADDRESS) && (next_state != LOAD_DATA);
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
  logic       full_state, rst_int_reg, busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .lfd_state(lfd_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  // Behavioural model: the packet phase the router is in and which port it owns.
  typedef enum int {IDLE, HEADER, BODY, STALL, RESUME, PARITY, PCHECK, WAITQ} phase_t;
  phase_t mph;
  int     mport;

  function automatic bit empty_of(input int p);
    bit e[3];
    e[0] = fifo_empty_0; e[1] = fifo_empty_1; e[2] = fifo_empty_2;
    return (p < 3) ? e[p] : 1'b0;
  endfunction

  function automatic bit soft_of(input int p);
    bit s[3];
    s[0] = soft_reset_0; s[1] = soft_reset_1; s[2] = soft_reset_2;
    return s[p];
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mph   = IDLE;
      mport = 0;
    end else if (mph != IDLE && soft_of(mport)) begin
      mph = IDLE;
    end else begin
      case (mph)
        IDLE: if (pkt_valid && int'(data_in) != 3) begin
          mport = int'(data_in);
          mph   = empty_of(mport) ? HEADER : WAITQ;
        end
        WAITQ:  if (empty_of(mport)) mph = HEADER;
        HEADER: mph = BODY;
        BODY:   if (fifo_full) mph = STALL; else if (!pkt_valid) mph = PARITY;
        STALL:  if (!fifo_full) mph = RESUME;
        RESUME: mph = parity_done ? IDLE : (low_pkt_valid ? PARITY : BODY);
        PARITY: mph = PCHECK;
        PCHECK: mph = fifo_full ? STALL : IDLE;
        default: mph = IDLE;
      endcase
    end
  end

  // Expected {write_enb, detect, ld, laf, lfd, full, rst_int, busy} for a phase.
  function automatic logic [7:0] expect_of(input phase_t p);
    logic we, bz;
    we = (p == BODY) || (p == PARITY) || (p == RESUME);
    bz = !((p == IDLE) || (p == BODY));
    return {we, p == IDLE, p == BODY, p == RESUME, p == HEADER, p == STALL, p == PCHECK, bz};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state,
            rst_int_reg, busy};
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    checks++;
    if (dut_vec() !== expect_of(mph)) begin
      errors++;
      $display("FAIL model_cmp t=%0t phase=%0d got=%b exp=%b", $time, mph, dut_vec(),
               expect_of(mph));
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  // Advance n clock edges; inputs change 2 time units after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; fifo_full = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    parity_done = 0; low_pkt_valid = 0;
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    step(2);
    chk("reset_detect", detect_add, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_we", write_enb_reg, 1'b0);
    resetn = 1;
    step(2);
    chk("idle_detect", detect_add, 1'b1);

    // Good packet to port 2, three payload bytes.
    pkt_valid = 1; data_in = 2'd2;
    step(1);
    chk("good_lfd", lfd_state, 1'b1);
    chk("good_lfd_busy", busy, 1'b1);
    step(1);
    chk("good_ld", ld_state, 1'b1);
    chk("good_ld_we", write_enb_reg, 1'b1);
    chk("good_ld_busy", busy, 1'b0);
    step(2);
    chk("good_ld3", ld_state, 1'b1);
    pkt_valid = 0;
    step(1);
    chk("good_lp_we", write_enb_reg, 1'b1);
    chk("good_lp_busy", busy, 1'b1);
    step(1);
    chk("good_rst_int", rst_int_reg, 1'b1);
    step(1);
    chk("good_back_decode", detect_add, 1'b1);
    chk("good_rst_int_off", rst_int_reg, 1'b0);

    // Destination busy: wait on port 1 for five cycles.
    pkt_valid = 1; data_in = 2'd1; fifo_empty_1 = 0;
    step(1);
    chk("wait_busy", busy, 1'b1);
    chk("wait_detect", detect_add, 1'b0);
    step(4);
    chk("wait_still", lfd_state, 1'b0);
    chk("wait_busy5", busy, 1'b1);
    fifo_empty_1 = 1;
    step(1);
    chk("wait_to_lfd", lfd_state, 1'b1);
    step(1);
    chk("wait_ld", ld_state, 1'b1);

    // FIFO full mid-payload, resuming into parity via low_pkt_valid.
    fifo_full = 1; pkt_valid = 0;
    step(1);
    chk("full_state", full_state, 1'b1);
    chk("full_we", write_enb_reg, 1'b0);
    fifo_full = 0; low_pkt_valid = 1;
    step(1);
    chk("laf_state", laf_state, 1'b1);
    chk("laf_we", write_enb_reg, 1'b1);
    step(1);
    chk("laf_to_lp_we", write_enb_reg, 1'b1);
    chk("laf_to_lp_ld", ld_state, 1'b0);
    low_pkt_valid = 0;
    step(2);
    chk("lp_done_decode", detect_add, 1'b1);

    // Full again on port 0, resuming back into payload.
    pkt_valid = 1; data_in = 2'd0;
    step(2);
    fifo_full = 1;
    step(1);
    fifo_full = 0;
    step(1);
    chk("laf2", laf_state, 1'b1);
    step(1);
    chk("laf_to_ld", ld_state, 1'b1);

    // Soft reset of another port is ignored; of the owning port aborts.
    soft_reset_2 = 1;
    step(1);
    chk("soft_other_ignored", ld_state, 1'b1);
    soft_reset_2 = 0; soft_reset_0 = 1; pkt_valid = 0;
    step(1);
    chk("soft_own_abort", detect_add, 1'b1);
    soft_reset_0 = 0;

    // Invalid address 3 never leaves decode.
    pkt_valid = 1; data_in = 2'd3;
    step(2);
    chk("inv_detect", detect_add, 1'b1);
    chk("inv_we", write_enb_reg, 1'b0);

    // Async reset while stalled on full.
    data_in = 2'd2;
    step(2);
    fifo_full = 1;
    step(1);
    chk("pre_rst_full", full_state, 1'b1);
    resetn = 0;
    #1;
    chk("async_full_clr", full_state, 1'b0);
    chk("async_detect", detect_add, 1'b1);
    chk("async_busy", busy, 1'b0);
    chk("async_we", write_enb_reg, 1'b0);
    idle_inputs();
    step(1);
    resetn = 1;
    step(1);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      pkt_valid     = ($urandom_range(0, 9) < 7);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 9) < 2);
      fifo_empty_0  = ($urandom_range(0, 9) < 7);
      fifo_empty_1  = ($urandom_range(0, 9) < 7);
      fifo_empty_2  = ($urandom_range(0, 9) < 7);
      soft_reset_0  = ($urandom_range(0, 99) < 3);
      soft_reset_1  = ($urandom_range(0, 99) < 3);
      soft_reset_2  = ($urandom_range(0, 99) < 3);
      parity_done   = ($urandom_range(0, 9) < 3);
      low_pkt_valid = ($urandom_range(0, 9) < 4);
      resetn        = ($urandom_range(0, 199) != 0);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
